sram_controller: RTL and testbench

//  Sequences 32-bit MEM-stage loads/stores onto an external 16-bit asynchronous SRAM as two half-word accesses.

---
 rtl/sram_controller.sv | 114 +++++++++++
 tb/tb_sram_controller.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
`timescale 1ns/1ps
// Splits 32-bit pipeline loads/stores into two half-word accesses on a 16-bit async SRAM.
// Holds 'ready' low while an access is in flight so the pipeline stays frozen.
module sram_controller #(
    parameter int unsigned ADDR_BASE   = 1024,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_r_en,
    input  logic               mem_w_en,
    input  logic [31:0]        address,
    input  logic [31:0]        wr_data,
    output logic [31:0]        rd_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    inout  wire  [15:0]        sram_dq,
    output logic               sram_we_n,
    output logic               sram_oe_n,
    output logic               sram_ce_n
);

    typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

    localparam logic [3:0]  Wait = 4'(WAIT_CYCLES);
    localparam logic [31:0] Base = 32'(ADDR_BASE);

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               op_wr_q, op_wr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [SRAM_AW-2:0] waddr_q, waddr_d;
    logic [31:0]        waddr_full;
    logic               unused_waddr;
    logic               req;
    logic               phase_d;
    logic [15:0]        dq_out_q;
    logic               dq_oe_q;

    assign req          = mem_r_en | mem_w_en;
    assign ready        = (state_q == StIdle && !req) || state_q == StDone;
    assign waddr_full   = (address - Base) >> 2;
    assign unused_waddr = ^waddr_full[31:SRAM_AW-1];
    assign sram_dq      = dq_oe_q ? dq_out_q : 16'hzzzz;
    assign phase_d      = (state_d == StLo) || (state_d == StHi);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        wdata_d = wdata_q;
        waddr_d = waddr_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    state_d = StLo;
                    cnt_d   = Wait;
                    // A simultaneous read and write request is treated as a store.
                    op_wr_d = mem_w_en;
                    wdata_d = wr_data;
                    waddr_d = waddr_full[SRAM_AW-2:0];
                end
            end
            StLo, StHi: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    cnt_d   = Wait;
                    state_d = (state_q == StLo) ? StHi : StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // SRAM strobes are registered from next-state so they are glitch-free in each phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            op_wr_q   <= 1'b0;
            wdata_q   <= 32'd0;
            waddr_q   <= '0;
            rd_data   <= 32'd0;
            sram_addr <= '0;
            sram_we_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_ce_n <= 1'b1;
            dq_out_q  <= 16'd0;
            dq_oe_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_wr_q   <= op_wr_d;
            wdata_q   <= wdata_d;
            waddr_q   <= waddr_d;
            sram_ce_n <= !phase_d;
            sram_we_n <= !(phase_d && op_wr_d && cnt_d != 4'd0);
            sram_oe_n <= !(phase_d && !op_wr_d);
            dq_oe_q   <= phase_d && op_wr_d;
            dq_out_q  <= (state_d == StHi) ? wdata_d[31:16] : wdata_d[15:0];
            if (phase_d) begin
                sram_addr <= {waddr_d, state_d == StHi};
            end
            if (!op_wr_q && cnt_q == 4'd0) begin
                if (state_q == StLo) rd_data[15:0] <= sram_dq;
                if (state_q == StHi) rd_data[31:16] <= sram_dq;
            end
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
`timescale 1ns/1ps
// Scoreboard bench for sram_controller: directed loads/stores against a behavioural SRAM,
// plus a second instance with WAIT_CYCLES = 3 for stretched phases.
module tb_sram_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        r_en, w_en;
    logic [31:0] addr, wdata, rd_data;
    logic        ready;
    logic [17:0] sram_addr;
    wire  [15:0] sram_dq;
    logic        we_n, oe_n, ce_n;

    logic        r3, w3;
    logic [31:0] addr3, wd3, rd3;
    logic        ready3;
    logic [17:0] sa3;
    wire  [15:0] dq3;
    logic        we3_n, oe3_n, ce3_n;

    logic [15:0] mem  [0:255] = '{default: 16'h0};
    logic [15:0] mem3 [0:255] = '{default: 16'h0};

    int checks = 0;
    int errors = 0;
    int low_cnt = 0;
    int lo3 = 0, wl3 = 0, wh3 = 0;

    typedef struct {
        string       name;
        logic [31:0] rd;
        int          lat;
    } exp_t;
    typedef struct {
        logic [17:0] a;
        logic [15:0] d;
    } wr_t;

    exp_t exp_q[$];
    wr_t  wq[$];

    always #5 clk = ~clk;

    sram_controller dut (
        .clk(clk), .rst(rst), .mem_r_en(r_en), .mem_w_en(w_en), .address(addr),
        .wr_data(wdata), .rd_data(rd_data), .ready(ready), .sram_addr(sram_addr),
        .sram_dq(sram_dq), .sram_we_n(we_n), .sram_oe_n(oe_n), .sram_ce_n(ce_n)
    );

    sram_controller #(.WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .mem_r_en(r3), .mem_w_en(w3), .address(addr3),
        .wr_data(wd3), .rd_data(rd3), .ready(ready3), .sram_addr(sa3),
        .sram_dq(dq3), .sram_we_n(we3_n), .sram_oe_n(oe3_n), .sram_ce_n(ce3_n)
    );

    for (genvar i = 0; i < 16; i++) begin : g_pu
        pullup (sram_dq[i]);
    end

    assign sram_dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr[7:0]] : 16'hzzzz;
    assign dq3     = (!ce3_n && !oe3_n && we3_n) ? mem3[sa3[7:0]] : 16'hzzzz;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: completions (ready with request) and SRAM write strobes, sampled mid-cycle.
    initial forever begin
        exp_t e;
        wr_t  w;
        @(negedge clk);
        if (rst) begin
            low_cnt = 0;
        end else if (!ready) begin
            low_cnt++;
        end else if (r_en || w_en) begin
            if (exp_q.size() == 0) begin
                chk("unexpected completion", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk({e.name, " rd_data"}, rd_data, e.rd);
                chk({e.name, " ready-low cycles"}, 32'(low_cnt), 32'(e.lat));
            end
            low_cnt = 0;
        end else begin
            low_cnt = 0;
        end
        if (!rst && !ce_n && !we_n) begin
            mem[sram_addr[7:0]] = sram_dq;
            if (wq.size() == 0) begin
                chk("unexpected write strobe", {14'd0, sram_addr}, 32'hffffffff);
            end else begin
                w = wq.pop_front();
                chk("write sram_addr", {14'd0, sram_addr}, {14'd0, w.a});
                chk("write sram_dq", {16'd0, sram_dq}, {16'd0, w.d});
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (!ready3 && (r3 || w3)) lo3++;
            if (!ce3_n && !we3_n) begin
                mem3[sa3[7:0]] = dq3;
                if (sa3[0]) wh3++;
                else wl3++;
            end
        end
    end

    task automatic wait_done(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk({name, " timeout"}, 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd, input string name);
        w_en  = w;
        r_en  = r;
        addr  = a;
        wdata = d;
        exp_q.push_back('{name: name, rd: exp_rd, lat: 5});
        wait_done(name);
    endtask

    task automatic idle();
        w_en = 1'b0;
        r_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic pw(input logic [17:0] a, input logic [15:0] d);
        wq.push_back('{a: a, d: d});
    endtask

    task automatic wait3(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (ready3) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk({name, " timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        r_en = 1'b0; w_en = 1'b0; addr = 32'd0; wdata = 32'd0;
        r3 = 1'b0; w3 = 1'b0; addr3 = 32'd0; wd3 = 32'd0;
        #12;
        chk("reset ready", {31'd0, ready}, 32'd1);
        chk("reset strobes", {29'd0, we_n, oe_n, ce_n}, 32'd7);
        chk("reset dq released", {16'd0, sram_dq}, 32'h0000ffff);
        chk("reset rd_data", rd_data, 32'd0);
        chk("reset sram_addr", {14'd0, sram_addr}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        pw(18'd0, 16'hBEEF); pw(18'd1, 16'hDEAD);
        op(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 32'h0, "t1 store");
        idle();
        op(1'b0, 1'b1, 32'd1024, 32'h0, 32'hDEADBEEF, "t1 load");
        idle();

        pw(18'd2, 16'h5678); pw(18'd3, 16'h1234);
        op(1'b1, 1'b0, 32'd1028, 32'h12345678, 32'hDEADBEEF, "t2 store");
        idle();

        op(1'b0, 1'b1, 32'd1024, 32'h0, 32'hDEADBEEF, "t3 load a");
        op(1'b0, 1'b1, 32'd1028, 32'h0, 32'h12345678, "t3 load b");
        idle();

        pw(18'd4, 16'hA5A5); pw(18'd5, 16'hA5A5);
        op(1'b1, 1'b1, 32'd1032, 32'hA5A5A5A5, 32'h12345678, "t4 both");
        idle();
        op(1'b0, 1'b1, 32'd1032, 32'h0, 32'hA5A5A5A5, "t4 load");
        idle();

        // Reset while the high half of a store is being written.
        pw(18'd6, 16'hF00D);
        w_en = 1'b1; addr = 32'd1036; wdata = 32'h0BADF00D;
        exp_q.push_back('{name: "t5 store", rd: 32'h0, lat: 5});
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t5 async strobes", {29'd0, we_n, oe_n, ce_n}, 32'd7);
        chk("t5 dq released", {16'd0, sram_dq}, 32'h0000ffff);
        chk("t5 rd_data cleared", rd_data, 32'd0);
        chk("t5 ready in reset", {31'd0, ready}, 32'd0);
        pw(18'd6, 16'hF00D); pw(18'd7, 16'h0BAD);
        @(posedge clk); #1;
        rst = 1'b0;
        wait_done("t5 store");
        idle();
        op(1'b0, 1'b1, 32'd1036, 32'h0, 32'h0BADF00D, "t5 load");
        idle();

        // Address below the base wraps into the top of the SRAM.
        pw(18'h3FFFE, 16'h2222); pw(18'h3FFFF, 16'h1111);
        op(1'b1, 1'b0, 32'd1020, 32'h11112222, 32'h0BADF00D, "wrap store");
        idle();
        op(1'b0, 1'b1, 32'd1020, 32'h0, 32'h11112222, "wrap load");
        idle();

        chk("write queue drained", 32'(wq.size()), 32'd0);
        chk("completion queue drained", 32'(exp_q.size()), 32'd0);

        lo3 = 0; wl3 = 0; wh3 = 0;
        w3 = 1'b1; addr3 = 32'd1024; wd3 = 32'hCAFE0001;
        wait3("w3 store");
        chk("w3 store ready-low cycles", 32'(lo3), 32'd9);
        chk("w3 we_n low in LO", 32'(wl3), 32'd3);
        chk("w3 we_n low in HI", 32'(wh3), 32'd3);
        @(posedge clk); #1;
        w3 = 1'b0;
        @(posedge clk); #1;
        lo3 = 0;
        r3 = 1'b1;
        wait3("w3 load");
        chk("w3 load ready-low cycles", 32'(lo3), 32'd9);
        chk("w3 load rd_data", rd3, 32'hCAFE0001);
        @(posedge clk); #1;
        r3 = 1'b0;
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
